// File: rtl/rob_banked.sv
// rob_banked: banked reorder buffer with WIDTH-wide in-order allocate and retire, updated from CDB lanes
//   Interleaves CHANNELS banks of DEPTH entries; global tag g lives in bank g%CHANNELS, row g/CHANNELS.
//   Ports: clk, rst (sync, active-high), flush; push_num/push_data/alloc_tag (dispatch side);
//   free_cnt, empty; head_data/head_ready/pop_num (commit side); cdb (writeback lanes).
//   Optional ROB_CDB_BYPASS_EN: head outputs see same-cycle CDB hits so an entry can retire as it completes.
`ifndef ROB_SIZE
`define ROB_SIZE 16
`endif
`ifndef CDB_SIZE
`define CDB_SIZE 2
`endif

package rob_banked_pkg;
  localparam int ROB_SIZE = `ROB_SIZE;
  localparam int TAG_W = $clog2(ROB_SIZE);
  typedef struct packed {
    logic       valid;
    logic [3:0] cause;
  } rob_ex_t;
  typedef struct packed {
    logic        busy;
    logic [31:0] value;
    logic [31:0] data;
    rob_ex_t     ex;
  } rob_entry_t;
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] reorder;
    logic [31:0]      value;
    logic [31:0]      data;
    rob_ex_t          ex;
  } cdb_lane_t;
  typedef cdb_lane_t [`CDB_SIZE-1:0] cdb_packet_t;
  function automatic rob_entry_t cdb_merge(rob_entry_t e, cdb_lane_t l);
    rob_entry_t r;
    r = e;
    r.busy = 1'b0;
    r.value = e.value | l.value;
    r.data = e.data | l.data;
    r.ex = e.ex | l.ex;
    return r;
  endfunction
endpackage

module rob_banked
  import rob_banked_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int DEPTH = 8,
  parameter int WIDTH = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [$clog2(WIDTH+1)-1:0]        push_num,
  input  rob_entry_t [WIDTH-1:0]            push_data,
  output logic [WIDTH-1:0][TAG_W-1:0]       alloc_tag,
  output logic [$clog2(ROB_SIZE+1)-1:0]     free_cnt,
  output rob_entry_t [WIDTH-1:0]            head_data,
  output logic [WIDTH-1:0]                  head_ready,
  input  logic [$clog2(WIDTH+1)-1:0]        pop_num,
  output logic                              empty,
  input  cdb_packet_t                       cdb
);
  localparam int NW = $clog2(WIDTH+1);
  localparam int FW = $clog2(ROB_SIZE+1);
  if (CHANNELS * DEPTH != ROB_SIZE) begin : g_size_chk
    $error("CHANNELS*DEPTH must equal ROB_SIZE");
  end
  function automatic int bank_of(logic [TAG_W-1:0] g);
    return int'(g) % CHANNELS;
  endfunction
  function automatic int row_of(logic [TAG_W-1:0] g);
    return int'(g) / CHANNELS;
  endfunction
  rob_entry_t mem [CHANNELS][DEPTH];
  rob_entry_t mem_n [CHANNELS][DEPTH];
  logic vld [CHANNELS][DEPTH];
  logic vld_n [CHANNELS][DEPTH];
  logic [TAG_W-1:0] head, tail;
  logic [FW-1:0] free_q;
  logic push_ok;
  assign free_cnt = free_q;
  assign empty = free_q == FW'(ROB_SIZE);
  assign push_ok = FW'(push_num) <= free_q;
  for (genvar k = 0; k < WIDTH; k++) begin : g_tag
    assign alloc_tag[k] = tail + TAG_W'(k);
  end
  always_comb begin
    logic [TAG_W-1:0] g;
    rob_entry_t e;
    logic v, prev, any_ex, rdy;
    g = '0;
    e = '0;
    v = 1'b0;
    prev = 1'b1;
    any_ex = 1'b0;
    rdy = 1'b0;
    head_data = '0;
    head_ready = '0;
    for (int k = 0; k < WIDTH; k++) begin
      g = head + TAG_W'(k);
      e = mem[bank_of(g)][row_of(g)];
      v = vld[bank_of(g)][row_of(g)];
`ifdef ROB_CDB_BYPASS_EN
      for (int i = 0; i < `CDB_SIZE; i++)
        if (cdb[i].valid && cdb[i].reorder == g && v) e = cdb_merge(e, cdb[i]);
`endif
      head_data[k] = e;
      // younger slots may only retire alongside a clean, exception-free prefix
      rdy = v && !e.busy && prev && (k == 0 || (!e.ex.valid && !any_ex));
      head_ready[k] = rdy;
      prev = rdy;
      any_ex = any_ex | e.ex.valid;
    end
  end
  always_comb begin
    logic [TAG_W-1:0] g;
    g = '0;
    mem_n = mem;
    vld_n = vld;
    for (int i = 0; i < `CDB_SIZE; i++)
      if (cdb[i].valid && vld[bank_of(cdb[i].reorder)][row_of(cdb[i].reorder)])
        mem_n[bank_of(cdb[i].reorder)][row_of(cdb[i].reorder)] =
          cdb_merge(mem_n[bank_of(cdb[i].reorder)][row_of(cdb[i].reorder)], cdb[i]);
    for (int k = 0; k < WIDTH; k++) begin
      g = head + TAG_W'(k);
      if (NW'(k) < pop_num) begin
        mem_n[bank_of(g)][row_of(g)] = '0;
        vld_n[bank_of(g)][row_of(g)] = 1'b0;
      end
    end
    for (int k = 0; k < WIDTH; k++) begin
      g = tail + TAG_W'(k);
      if (push_ok && NW'(k) < push_num) begin
        mem_n[bank_of(g)][row_of(g)] = push_data[k];
        vld_n[bank_of(g)][row_of(g)] = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head <= '0;
      tail <= '0;
      free_q <= FW'(ROB_SIZE);
      for (int b = 0; b < CHANNELS; b++)
        for (int r = 0; r < DEPTH; r++) begin
          mem[b][r] <= '0;
          vld[b][r] <= 1'b0;
        end
    end else begin
      mem <= mem_n;
      vld <= vld_n;
      head <= head + TAG_W'(pop_num);
      tail <= push_ok ? tail + TAG_W'(push_num) : tail;
      free_q <= free_q - (push_ok ? FW'(push_num) : FW'(0)) + FW'(pop_num);
    end
  end
endmodule

// File: tb/tb_rob_banked.sv
// tb_rob_banked: directed scoreboard bench for rob_banked (default CHANNELS=2, DEPTH=8, WIDTH=2)
`ifndef ROB_SIZE
`define ROB_SIZE 16
`endif
module tb_rob_banked;
  import rob_banked_pkg::*;
  localparam int W = 2;
  localparam int RS = `ROB_SIZE;
  localparam int TW = $clog2(RS);
  localparam int FW = $clog2(RS+1);
  logic clk = 0, rst = 1, flush = 0;
  logic [1:0] push_num = 0, pop_num = 0;
  rob_entry_t [W-1:0] push_data, head_data;
  logic [W-1:0][TW-1:0] alloc_tag;
  logic [FW-1:0] free_cnt;
  logic [W-1:0] head_ready;
  logic empty;
  cdb_packet_t cdb;
  int checks = 0, errors = 0;
  rob_entry_t exp_mem [RS];
  int tag_q [$];
  logic [TW-1:0] mtail;
  int mfree;

  rob_banked #(.CHANNELS(2), .DEPTH(8), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .push_num(push_num), .push_data(push_data),
    .alloc_tag(alloc_tag), .free_cnt(free_cnt), .head_data(head_data), .head_ready(head_ready),
    .pop_num(pop_num), .empty(empty), .cdb(cdb)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // retire monitor: whatever commit takes must match the oldest allocated entry, as completed
  always @(negedge clk) begin
    if (!rst && pop_num != 0) begin
      chk("pop_legal", 128'(pop_num <= 2'($countones(head_ready))), 128'(1));
      for (int k = 0; k < W; k++) begin
        if (k < int'(pop_num)) begin
          if (tag_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL retire_underflow: got retire slot %0d expected no retire", k);
          end else begin
            int t;
            t = tag_q.pop_front();
            chk("retire_data", 128'(head_data[k]), 128'(exp_mem[t]));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    push_num = 0;
    pop_num = 0;
    flush = 0;
    cdb = '0;
    push_data = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
    tag_q.delete();
    mtail = '0;
    mfree = RS;
    foreach (exp_mem[i]) exp_mem[i] = '0;
  endtask

  task automatic push(int n, int id);
    logic [TW-1:0] t;
    push_num = 2'(n);
    for (int k = 0; k < n; k++) begin
      push_data[k] = '0;
      push_data[k].busy = 1'b1;
      push_data[k].value = 32'(id + k);
      t = TW'(int'(mtail) + k);
      chk("alloc_tag", 128'(alloc_tag[k]), 128'(t));
    end
    if (n <= mfree) begin
      for (int k = 0; k < n; k++) begin
        t = TW'(int'(mtail) + k);
        exp_mem[t] = push_data[k];
        tag_q.push_back(int'(t));
      end
      mtail = TW'(int'(mtail) + n);
      mfree -= n;
    end
  endtask

  task automatic pop(int n);
    pop_num = 2'(n);
    mfree += n;
  endtask

  task automatic hit(int lane, int tag, int d, bit exv);
    cdb[lane].valid = 1'b1;
    cdb[lane].reorder = TW'(tag);
    cdb[lane].value = '0;
    cdb[lane].data = 32'(d);
    cdb[lane].ex.valid = exv;
    cdb[lane].ex.cause = exv ? 4'h3 : 4'h0;
    exp_mem[tag].busy = 1'b0;
    exp_mem[tag].data = exp_mem[tag].data | 32'(d);
    exp_mem[tag].ex.valid = exp_mem[tag].ex.valid | exv;
    exp_mem[tag].ex.cause = exp_mem[tag].ex.cause | (exv ? 4'h3 : 4'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    cdb = '0;
    push_data = '0;
    // reset state and fill to capacity
    do_reset();
    chk("rst_free", 128'(free_cnt), 128'(16));
    chk("rst_empty", 128'(empty), 128'(1));
    chk("rst_ready", 128'(head_ready), 128'(0));
    chk("rst_head_data", 128'(head_data), 128'(0));
    chk("rst_tag0", 128'(alloc_tag[0]), 128'(0));
    chk("rst_tag1", 128'(alloc_tag[1]), 128'(1));
    for (int i = 0; i < 8; i++) begin
      push(2, 100 + 2 * i);
      chk("fill_bank", 128'(alloc_tag[0][0]), 128'(0));
      tick();
    end
    chk("full_free", 128'(free_cnt), 128'(0));
    chk("full_empty", 128'(empty), 128'(0));
    push(1, 200);
    tick();
    chk("drop_free", 128'(free_cnt), 128'(0));
    chk("drop_tail", 128'(alloc_tag[0]), 128'(0));
    for (int i = 0; i < 8; i++) begin
      hit(0, 2 * i, 'h40 + i, 0);
      hit(1, 2 * i + 1, 'h80 + i, 0);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      chk("drain_ready", 128'(head_ready), 128'(2'b11));
      pop(2);
      tick();
    end
    chk("drain_empty", 128'(empty), 128'(1));
    chk("drain_free", 128'(free_cnt), 128'(16));
    // out-of-order completion blocks the head until tag 0 finishes
    do_reset();
    push(2, 300);
    tick();
    push(2, 302);
    tick();
    hit(0, 1, 'h11, 0);
    tick();
    chk("ooo_ready_a", 128'(head_ready), 128'(2'b00));
    hit(0, 0, 'h10, 0);
`ifndef ROB_CDB_BYPASS_EN
    chk("ooo_ready_b", 128'(head_ready), 128'(2'b00));
`endif
    tick();
    chk("ooo_ready_c", 128'(head_ready), 128'(2'b11));
    chk("ooo_free_a", 128'(free_cnt), 128'(12));
    pop(2);
    tick();
    chk("ooo_free_b", 128'(free_cnt), 128'(14));
    chk("ooo_ready_d", 128'(head_ready), 128'(2'b00));
    // exception at the head retires alone
    do_reset();
    push(2, 400);
    tick();
    hit(0, 0, 'h20, 1);
    hit(1, 1, 'h21, 0);
    tick();
    chk("ex_ready_a", 128'(head_ready), 128'(2'b01));
    pop(1);
    tick();
    chk("ex_ready_b", 128'(head_ready), 128'(2'b01));
    pop(1);
    tick();
    chk("ex_empty", 128'(empty), 128'(1));
    // one allocation and one retirement per cycle across the wrap
    do_reset();
    for (int i = 0; i < 22; i++) begin
      if (i < 20) begin
        push(1, 500 + i);
        chk("wrap_bank", 128'(alloc_tag[0][0]), 128'(i % 2));
      end
      if (i >= 1 && i <= 20) hit(0, (i - 1) % 16, 'h1000 + i, 0);
      if (i >= 2) begin
        chk("wrap_ready", 128'(head_ready[0]), 128'(1));
        pop(1);
      end
      tick();
    end
    chk("wrap_empty", 128'(empty), 128'(1));
    chk("wrap_tag", 128'(alloc_tag[0]), 128'(4));
    // flush beats push, pop and CDB in the same cycle
    do_reset();
    push(2, 600);
    tick();
    hit(0, 0, 'h30, 0);
    tick();
    flush = 1;
    push(2, 602);
    pop(1);
    hit(0, 1, 'h31, 0);
    tick();
    tag_q.delete();
    mtail = '0;
    mfree = RS;
    chk("flush_empty", 128'(empty), 128'(1));
    chk("flush_free", 128'(free_cnt), 128'(16));
    chk("flush_tag", 128'(alloc_tag[0]), 128'(0));
    chk("flush_ready", 128'(head_ready), 128'(0));
`ifdef ROB_CDB_BYPASS_EN
    // same-cycle CDB hit on head tag 5 retires immediately
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push(2, 700 + 2 * i);
      tick();
    end
    hit(0, 0, 'h50, 0);
    hit(1, 1, 'h51, 0);
    tick();
    hit(0, 2, 'h52, 0);
    hit(1, 3, 'h53, 0);
    pop(2);
    tick();
    hit(0, 4, 'h54, 0);
    pop(2);
    tick();
    pop(1);
    tick();
    hit(0, 5, 'h55, 0);
    chk("byp_ready", 128'(head_ready[0]), 128'(1));
    chk("byp_data", 128'(head_data[0].data), 128'(32'h55));
    pop(1);
    tick();
    chk("byp_empty", 128'(empty), 128'(1));
`endif
    chk("sb_drained", 128'(tag_q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rob_banked.md
Name: rob_banked

Overview:
- Reorder buffer built from CHANNELS interleaved banks, each DEPTH entries deep; total capacity CHANNELS*DEPTH must equal `ROB_SIZE.
- Each cycle it allocates up to WIDTH entries in program order and retires up to WIDTH completed entries in order.
- Entries are updated from all `CDB_SIZE CDB lanes.
- Sits between dispatch (allocation, tag return) and commit (in-order retire). Replaces the single-push/single-pop per-channel FIFO arrangement.

Parameters:
- CHANNELS, 2, number of banks; power of two, >= 1.
- DEPTH, 8, entries per bank; power of two.
- WIDTH, 2, maximum allocations and retirements per cycle; 1 <= WIDTH <= CHANNELS.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  pipeline flush: empties the ROB.
- push_num  in  $clog2(WIDTH+1)  number of entries to allocate this cycle (0..WIDTH).
- push_data  in  WIDTH x rob_entry_t  entries in program order; slot 0 is oldest.
- alloc_tag  out  WIDTH x $clog2(`ROB_SIZE)  tags that slots 0..WIDTH-1 would receive this cycle.
- free_cnt  out  $clog2(`ROB_SIZE+1)  free entries, registered.
- head_data  out  WIDTH x rob_entry_t  oldest WIDTH entries; slot 0 is the head.
- head_ready  out  WIDTH  contiguous-from-bit-0 mask of retireable head entries.
- pop_num  in  $clog2(WIDTH+1)  entries retired this cycle; must not exceed the popcount of head_ready.
- empty  out  1  no valid entries.
- cdb  in  cdb_packet_t  writeback bus, `CDB_SIZE lanes.

Behaviour:
- Tag mapping: global index g in 0..`ROB_SIZE-1.
  - bank = g[$clog2(CHANNELS)-1:0]; row = upper bits.
  - Consecutive allocations rotate across banks.
- State: head and tail global pointers (wrap modulo `ROB_SIZE), occupancy count, and a valid bit per entry.
- Reset/flush: count=0, head=tail=0, all entries zeroed and invalid. Outputs after reset: free_cnt=`ROB_SIZE, empty=1, head_ready=0, head_data=0, alloc_tag[k]=k.
- flush has priority over same-cycle push, pop and CDB.
- Allocation:
  - alloc_tag[k] = tail+k mod `ROB_SIZE.
  - If push_num <= free_cnt, write slots 0..push_num-1 at those tags with valid=1 and advance tail by push_num.
  - If push_num > free_cnt, the whole push is dropped; no partial allocation.
  - Same-cycle pops do not add to free space.
- CDB update, per lane i with cdb[i].valid:
  - The entry at cdb[i].reorder, if valid, gets busy cleared; value, data and ex are OR-merged.
  - A hit on an invalid entry is ignored.
  - Multiple lanes may hit different entries in the same cycle.
  - Update takes effect in the next-cycle state.
- Head view: head_data[k] = entry at head+k.
  - head_ready[k] = 1 only when entry head+k is valid, busy=0, and head_ready[k-1]=1 (for k>0).
  - For k>0, entry head+k must also have ex.valid=0, and no older slot may have ex.valid=1. An excepting entry is therefore only ever retireable in slot 0.
- Retire: pop_num entries leave the head. They are zeroed and made invalid, and head advances by pop_num modulo `ROB_SIZE.
- Count: next count = count + accepted push - pop_num.
- Simultaneous push and pop to the same physical entry cannot happen while count<`ROB_SIZE. If it does happen at full, push was already refused.
- Illegal pop_num (greater than the head_ready popcount): behaviour undefined; flagged by a bench assertion.

Optional Feature:
- ROB_CDB_BYPASS_EN defined:
  - head_data and head_ready include same-cycle CDB hits combinationally, so an entry completed this cycle may retire this cycle.
  - Latency from CDB to retire is 0 cycles.
- Undefined: head outputs reflect registered state only; CDB-to-retire latency is 1 cycle.

Test Plan:
- Reset, then push_num=2 for 8 cycles -> tags issued 0..15 in order, then free_cnt=0. Next push_num=1 is dropped; tail stays 0.
- Allocate tags 0..3; CDB completes tag 1 then tag 0 -> head_ready=2'b00 until tag 0 is done. The cycle after tag 0's CDB, head_ready=2'b11 (without bypass). Pop 2 -> free_cnt=14.
- Allocate 0..1; tag 0 completes with ex.valid=1, tag 1 completes clean -> head_ready=2'b01. After pop 1, head_ready=2'b01 for tag 1.
- Wrap: run 20 allocations and 20 retirements at 1/cycle -> tags wrap 15->0, and bank selection alternates 0,1,0,1 throughout.
- Flush asserted in the same cycle as push_num=2, pop_num=1 and a CDB hit -> next cycle empty=1, free_cnt=16, alloc_tag[0]=0.
- With ROB_CDB_BYPASS_EN, a CDB hit on head tag 5 -> head_ready[0]=1 in the same cycle; pop_num=1 accepted.
